// File: rtl/spi_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_master
// Brief    : single-byte SPI master, mode 0, MSB first, byte handshake I/F
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_master #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_dv_i,
  input  logic [7:0] tx_byte_i,
  output logic       tx_ready_o,
  output logic       rx_dv_o,
  output logic [7:0] rx_byte_o,
  output logic       spi_clk_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       cs_no
);

  localparam int c_cnt_max = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ?
                             CLKS_PER_HALF_BIT : CS_INACTIVE_CLKS;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_HALF_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(CS_INACTIVE_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [4:0]         r_edge_cnt;
  logic [6:0]         r_tx_shift;
  logic [7:0]         r_rx_shift;
  logic [7:0]         r_rx_byte;
  logic               r_tx_ready;
  logic               r_rx_dv;
  logic               r_sck;
  logic               r_mosi;
  logic               r_cs_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_tx_ready <= 1'b1;
      r_rx_dv    <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_rx_dv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_dv_i) begin
            r_tx_shift <= tx_byte_i[6:0];
            r_mosi     <= tx_byte_i[7];
            r_cs_n     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_SETUP;
          end
        end
        // Leaving SETUP is SCK edge 0 (first rise), so XFER owns edges 1..15
        // plus the trailing low half-period after the final fall.
        S_SETUP: begin
          if (r_cnt == c_half_last) begin
            r_cnt      <= '0;
            r_sck      <= 1'b1;
            r_rx_shift <= {r_rx_shift[6:0], miso_i};
            r_edge_cnt <= 5'd1;
            r_state    <= S_XFER;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (r_cnt == c_half_last) begin
            r_cnt <= '0;
            if (r_edge_cnt == 5'd16) begin
              r_state <= S_HOLD;
            end else begin
              r_sck      <= ~r_sck;
              r_edge_cnt <= r_edge_cnt + 5'd1;
              if (!r_edge_cnt[0]) begin
                r_rx_shift <= {r_rx_shift[6:0], miso_i};
              end else if (r_edge_cnt != 5'd15) begin
                r_mosi     <= r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt == c_half_last) begin
            r_cnt     <= '0;
            r_cs_n    <= 1'b1;
            r_rx_byte <= r_rx_shift;
            r_rx_dv   <= 1'b1;
            r_state   <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == c_gap_last) begin
            r_cnt      <= '0;
            r_tx_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_ready <= 1'b1;
          r_cs_n     <= 1'b1;
          r_sck      <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready_o = r_tx_ready;
  assign rx_dv_o    = r_rx_dv;
  assign rx_byte_o  = r_rx_byte;
  assign spi_clk_o  = r_sck;
  assign mosi_o     = r_mosi;
  assign cs_no      = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_byte_master
// Brief    : self-checking bench for spi_byte_master (H=2 and H=1 instances)
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_byte_master;

  localparam int H_A = 2;
  localparam int H_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // instance A: H=2, CS gap 1
  logic       a_dv = 1'b0;
  logic [7:0] a_byte = 8'h00;
  logic       a_ready, a_rx_dv, a_sck, a_mosi, a_miso, a_cs;
  logic [7:0] a_rx_byte;
  logic       a_loop = 1'b1;
  logic       a_slave_bit = 1'b0;
  assign a_miso = a_loop ? a_mosi : a_slave_bit;

  // instance B: H=1, CS gap 1, loopback
  logic       b_dv = 1'b0;
  logic [7:0] b_byte = 8'h00;
  logic       b_ready, b_rx_dv, b_sck, b_mosi, b_cs;
  logic [7:0] b_rx_byte;

  spi_byte_master #(.CLKS_PER_HALF_BIT(H_A), .CS_INACTIVE_CLKS(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tx_dv_i(a_dv), .tx_byte_i(a_byte),
    .tx_ready_o(a_ready), .rx_dv_o(a_rx_dv), .rx_byte_o(a_rx_byte),
    .spi_clk_o(a_sck), .mosi_o(a_mosi), .miso_i(a_miso), .cs_no(a_cs)
  );

  spi_byte_master #(.CLKS_PER_HALF_BIT(H_B), .CS_INACTIVE_CLKS(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tx_dv_i(b_dv), .tx_byte_i(b_byte),
    .tx_ready_o(b_ready), .rx_dv_o(b_rx_dv), .rx_byte_o(b_rx_byte),
    .spi_clk_o(b_sck), .mosi_o(b_mosi), .miso_i(b_mosi), .cs_no(b_cs)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte on instance A. Reference: MOSI carries tx MSB-first at the 8 SCK
  // rises, received byte is tx (loopback) or the slave's byte, CS low 18*H.
  task automatic xfer_a(input logic [7:0] tx, input logic [7:0] slv,
                        input bit loop, input bit poke);
    int cyc = 0, cs_low = 0, rises = 0, dv = 0, dv_at = -1, rdy_at = -1;
    logic [7:0] mo = '0, rxv = '0, sh, exp_rx;
    logic cs_at_dv = 1'b0, prev_sck = 1'b0;
    bit poked = 0;
    sh = slv;
    exp_rx = loop ? tx : slv;
    a_loop = loop;
    a_slave_bit = slv[7];
    @(negedge clk); a_dv = 1'b1; a_byte = tx;
    @(negedge clk); a_dv = 1'b0; a_byte = 8'($urandom);
    while (rdy_at < 0 && cyc < 400) begin
      if (!a_cs) cs_low++;
      if (a_sck && !prev_sck) begin rises++; mo = {mo[6:0], a_mosi}; end
      if (!a_sck && prev_sck) begin sh = sh << 1; a_slave_bit = sh[7]; end
      prev_sck = a_sck;
      if (a_rx_dv) begin dv++; dv_at = cyc; rxv = a_rx_byte; cs_at_dv = a_cs; end
      if (a_ready && dv > 0) rdy_at = cyc;
      if (poke && rises == 3 && !poked) begin a_dv = 1'b1; a_byte = 8'h55; poked = 1; end
      else a_dv = 1'b0;
      cyc++;
      if (rdy_at < 0) @(negedge clk);
    end
    chk("xfer_done_in_time", 32'(rdy_at >= 0), 32'd1);
    chk("mosi_bits", 32'(mo), 32'(tx));
    chk("sck_rises", 32'(rises), 32'd8);
    chk("cs_low_cycles", 32'(cs_low), 32'(18 * H_A));
    chk("rx_dv_pulses", 32'(dv), 32'd1);
    chk("rx_byte", 32'(rxv), 32'(exp_rx));
    chk("cs_high_at_rx_dv", 32'(cs_at_dv), 32'd1);
    chk("ready_after_rx_dv", 32'(rdy_at), 32'(dv_at + 1));
  endtask

  int falls, hi, gap, rises_b, n_dv, n_cs_low;
  logic pcs, psck;
  logic [7:0] rxq[$];

  initial begin
    // asynchronous reset, mid-cycle, no clock edge yet
    #3 rst_n = 1'b0;
    #1;
    chk("rst_cs_n", 32'(a_cs), 32'd1);
    chk("rst_sck", 32'(a_sck), 32'd0);
    chk("rst_mosi", 32'(a_mosi), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_rx_dv", 32'(a_rx_dv), 32'd0);
    chk("rst_rx_byte", 32'(a_rx_byte), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    xfer_a(8'hA5, 8'h00, 1'b1, 1'b0);
    xfer_a(8'h3C, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) xfer_a(8'($urandom), 8'($urandom), 1'b0, 1'b0);

    // busy strobe must be dropped, not queued
    xfer_a(8'h0F, 8'h00, 1'b1, 1'b1);
    n_dv = 0; n_cs_low = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_rx_dv) n_dv++;
      if (!a_cs) n_cs_low++;
    end
    chk("busy_no_second_cs", 32'(n_cs_low), 32'd0);
    chk("busy_no_second_dv", 32'(n_dv), 32'd0);

    // back-to-back on instance B with tx_dv held high
    falls = 0; hi = 0; gap = -1; rises_b = 0; pcs = 1'b1; psck = 1'b0;
    rxq.delete();
    b_dv = 1'b1; b_byte = 8'h01;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (!b_cs && pcs) begin
        falls++;
        if (falls == 1) b_byte = 8'hFF;
        else begin b_dv = 1'b0; if (gap < 0) gap = hi; end
      end
      hi = b_cs ? hi + 1 : 0;
      if (b_sck && !psck) rises_b++;
      if (b_rx_dv) rxq.push_back(b_rx_byte);
      pcs = b_cs; psck = b_sck;
    end
    b_dv = 1'b0;
    chk("b2b_cs_falls", 32'(falls), 32'd2);
    // high for the GAP cycle plus the IDLE cycle in which tx_ready_o=1 is seen
    chk("b2b_cs_high_gap", 32'(gap), 32'd2);
    chk("b2b_sck_rises", 32'(rises_b), 32'd16);
    chk("b2b_rx_count", 32'(rxq.size()), 32'd2);
    chk("b2b_rx0", 32'(rxq.size() > 0 ? rxq[0] : 8'hxx), 32'h01);
    chk("b2b_rx1", 32'(rxq.size() > 1 ? rxq[1] : 8'hxx), 32'hFF);

    // abort after the 5th SCK rise
    a_loop = 1'b1;
    @(negedge clk); a_dv = 1'b1; a_byte = 8'h5A;
    @(negedge clk); a_dv = 1'b0;
    rises_b = 0; psck = 1'b0;
    for (int c = 0; c < 200 && rises_b < 5; c++) begin
      if (a_sck && !psck) rises_b++;
      psck = a_sck;
      if (rises_b < 5) @(negedge clk);
    end
    chk("abort_reached_rise5", 32'(rises_b), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(a_cs), 32'd1);
    chk("abort_sck", 32'(a_sck), 32'd0);
    chk("abort_mosi", 32'(a_mosi), 32'd0);
    chk("abort_ready", 32'(a_ready), 32'd1);
    chk("abort_rx_dv", 32'(a_rx_dv), 32'd0);
    chk("abort_rx_byte", 32'(a_rx_byte), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n_dv = 0; n_cs_low = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_rx_dv) n_dv++;
      if (!a_cs) n_cs_low++;
    end
    chk("abort_no_rx_dv", 32'(n_dv), 32'd0);
    chk("abort_cs_stays_high", 32'(n_cs_low), 32'd0);
    xfer_a(8'h81, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
